dma_ch_sel: RTL and testbench

- Channel selector directly downstream of the DMA request arbiter. Consumes the per-channel `ch_req` vector that the request arbiter produces.
- Selects one channel at a time for the DMA transfer engine, using static priority with round-robin among equal priorities.
- Holds the grant until the engine reports completion or the channel is disabled, then releases and re-arbitrates.

---
 rtl/dma_ch_sel.sv | 108 ++++++++++
 tb/tb_dma_ch_sel.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_ch_sel.sv
// DMA channel selector: static priority with round-robin among equals.
// Holds a grant until the chunk completes or the channel is disabled.
module dma_ch_sel #(
  parameter int channel_number      = 31,
  parameter int channel_number_bits = $clog2(channel_number),
  parameter int prio_bits           = 3
) (
  input  logic                           HCLK,
  input  logic                           HRESETn,
  input  logic [channel_number-1:0]      ch_req,
  input  logic [channel_number-1:0]      ch_enable,
  input  logic [prio_bits-1:0]           ch_prio [0:channel_number-1],
  input  logic                           xfer_done,
  output logic                           grant_valid,
  output logic [channel_number_bits-1:0] grant_ch,
  output logic [channel_number-1:0]      grant_onehot,
  output logic                           grant_abort,
  output logic                           busy
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    RELEASE
  } state_t;

  localparam logic [channel_number_bits-1:0] LAST_IDX =
    channel_number_bits'(channel_number - 1);
  localparam logic [channel_number-1:0] ONE =
    channel_number'(1);

  state_t                         state;
  logic [channel_number_bits-1:0] last_grant;
  logic [channel_number-1:0]      elig;
  logic [prio_bits-1:0]           max_prio;
  logic [channel_number_bits-1:0] start;
  logic [channel_number_bits-1:0] sel;
  logic [channel_number_bits-1:0] idx_b;
  logic                           found;
  int                             idx;

  assign elig  = ch_req & ch_enable;
  assign start = (last_grant == LAST_IDX) ? '0 : last_grant + 1'b1;
  assign busy  = (state != IDLE);

  always_comb begin
    max_prio = '0;
    for (int i = 0; i < channel_number; i++) begin
      if (elig[i] && (ch_prio[i] > max_prio)) max_prio = ch_prio[i];
    end
  end

  // Wrap by compare so non-power-of-two channel counts work.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    idx   = 0;
    idx_b = '0;
    for (int i = 0; i < channel_number; i++) begin
      idx = int'(start) + i;
      if (idx > channel_number - 1) idx = idx - channel_number;
      idx_b = idx[channel_number_bits-1:0];
      if (!found && elig[idx_b] && (ch_prio[idx_b] == max_prio)) begin
        sel   = idx_b;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state        <= IDLE;
      last_grant   <= LAST_IDX;
      grant_valid  <= 1'b0;
      grant_ch     <= '0;
      grant_onehot <= '0;
      grant_abort  <= 1'b0;
    end else begin
      grant_abort <= 1'b0;
      unique case (state)
        IDLE: begin
          if (elig != '0) begin
            grant_ch     <= sel;
            grant_onehot <= ONE << sel;
            grant_valid  <= 1'b1;
            state        <= GRANT;
          end
        end
        GRANT: begin
          if (xfer_done || !ch_enable[grant_ch]) begin
            last_grant   <= grant_ch;
            grant_valid  <= 1'b0;
            grant_onehot <= '0;
            grant_abort  <= !xfer_done;
            state        <= RELEASE;
          end
        end
        RELEASE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dma_ch_sel.sv
// Bench for dma_ch_sel: directed scenarios plus random traffic
// compared cycle by cycle against a transaction-level model.
module tb_dma_ch_sel;

  localparam int N = 31;

  logic         HCLK = 1'b0;
  logic         HRESETn = 1'b1;
  logic [N-1:0] req;
  logic [N-1:0] en;
  logic [2:0]   prio [0:N-1];
  logic         done;
  logic         gv;
  logic [4:0]   gch;
  logic [N-1:0] goh;
  logic         gab;
  logic         busy;

  int total = 0;
  int bad   = 0;

  int m_ph;
  int m_own;
  int m_last;
  bit m_valid;
  bit m_abort;

  dma_ch_sel dut (
    .HCLK         (HCLK),
    .HRESETn      (HRESETn),
    .ch_req       (req),
    .ch_enable    (en),
    .ch_prio      (prio),
    .xfer_done    (done),
    .grant_valid  (gv),
    .grant_ch     (gch),
    .grant_onehot (goh),
    .grant_abort  (gab),
    .busy         (busy)
  );

  always #5 HCLK = ~HCLK;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Highest priority wins; ties go to smallest distance after m_last.
  function automatic int pick(logic [N-1:0] e);
    int best = -1;
    int bp   = -1;
    int bd   = N;
    int d;
    for (int c = 0; c < N; c++) begin
      if (e[c]) begin
        d = (c - m_last - 1 + 2 * N) % N;
        if (int'(prio[c]) > bp || (int'(prio[c]) == bp && d < bd)) begin
          best = c;
          bp   = int'(prio[c]);
          bd   = d;
        end
      end
    end
    return best;
  endfunction

  task automatic model_edge();
    logic [N-1:0] e;
    e = req & en;
    m_abort = 1'b0;
    if (m_ph == 0) begin
      if (e != '0) begin
        m_own   = pick(e);
        m_valid = 1'b1;
        m_ph    = 1;
      end
    end else if (m_ph == 1) begin
      if (done || !en[m_own]) begin
        m_abort = !done;
        m_last  = m_own;
        m_valid = 1'b0;
        m_ph    = 2;
      end
    end else begin
      m_ph = 0;
    end
  endtask

  task automatic cmp_all();
    logic [63:0] oh;
    oh = m_valid ? (64'd1 << m_own) : 64'd0;
    check("valid", gv, m_valid);
    check("onehot", goh, oh);
    if (m_valid) check("ch", gch, m_own);
    check("abort", gab, m_abort);
    check("busy", busy, m_ph != 0);
  endtask

  task automatic step();
    @(posedge HCLK);
    model_edge();
    #1;
    cmp_all();
  endtask

  task automatic do_reset();
    req  = '0;
    en   = '0;
    done = 1'b0;
    HRESETn = 1'b0;
    #2;
    check("rst_valid", gv, 0);
    check("rst_ch", gch, 0);
    check("rst_onehot", goh, 0);
    check("rst_abort", gab, 0);
    check("rst_busy", busy, 0);
    m_ph = 0; m_own = 0; m_last = N - 1;
    m_valid = 1'b0; m_abort = 1'b0;
    @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
  endtask

  task automatic wait_grant(output int ch);
    int n = 0;
    while (!gv && n < 20) begin
      step();
      n++;
    end
    check("grant_seen", gv, 1);
    ch = int'(gch);
  endtask

  task automatic finish_grant();
    done = 1'b1;
    step();
    done = 1'b0;
  endtask

  task automatic set_prio(int p);
    for (int i = 0; i < N; i++) prio[i] = 3'(p);
  endtask

  initial begin
    int ch;
    int n;
    int order [4] = '{0, 1, 2, 0};
    set_prio(0);
    #1;
    do_reset();

    req = 31'h1; en = 31'h1;
    step();
    check("first_valid", gv, 1);
    check("first_ch", gch, 0);
    check("first_onehot", goh, 1);
    check("first_busy", busy, 1);

    do_reset();
    set_prio(2);
    req = 31'h7; en = 31'h7;
    for (int k = 0; k < 4; k++) begin
      wait_grant(ch);
      check("rr_order", ch, order[k]);
      done = 1'b1;
      step();
      done = 1'b0;
      n = 1;
      while (!gv && n < 10) begin
        step();
        n++;
      end
      check("rr_gap", n, 3);
    end

    do_reset();
    set_prio(0);
    prio[1] = 3'd1; prio[2] = 3'd5;
    req = 31'h6; en = 31'h6;
    repeat (3) begin
      wait_grant(ch);
      check("prio_hi", ch, 2);
      finish_grant();
    end
    req = 31'h2;
    wait_grant(ch);
    check("prio_lo", ch, 1);

    do_reset();
    set_prio(3);
    req = 31'h1 << 30; en = req;
    wait_grant(ch);
    check("last_30", ch, 30);
    finish_grant();
    req = (31'h1 << 30) | 31'h1; en = req;
    wait_grant(ch);
    check("wrap", ch, 0);

    do_reset();
    req = 31'h30; en = 31'h30;
    wait_grant(ch);
    check("abort_own", ch, 4);
    en[4] = 1'b0;
    step();
    check("abort_pulse", gab, 1);
    check("abort_drop", gv, 0);
    step();
    check("abort_once", gab, 0);
    wait_grant(ch);
    check("after_abort", ch, 5);

    do_reset();
    req = 31'h10; en = 31'h10;
    wait_grant(ch);
    en = '0;
    done = 1'b1;
    step();
    done = 1'b0;
    check("done_wins", gab, 0);
    check("done_drop", gv, 0);

    do_reset();
    req = 31'h1; en = 31'h1;
    wait_grant(ch);
    finish_grant();
    req = 31'h11; en = 31'h11;
    wait_grant(ch);
    check("pre_rst", ch, 4);
    do_reset();
    req = 31'h11; en = 31'h11;
    wait_grant(ch);
    check("rst_search", ch, 0);

    do_reset();
    repeat (3000) begin
      req  = $urandom & $urandom & $urandom;
      en   = ~($urandom & $urandom & $urandom);
      done = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < N; i++) prio[i] = 3'($urandom_range(0, 7));
      step();
      check("inv_excl", gv & gab, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
